logic_unit_seq: RTL and testbench

Parametrised, multi-cycle bitwise logic unit; successor to the fixed 16-bit single-function gate arrays in the ALU. It performs one of eight bitwise operations on two WIDTH-bit operands, SLICE bits per clock, under a start/busy/done handshake. It also produces a zero flag and a population count of the result. The ALU controller issues one operation at a time and reads the results on done.

---
 rtl/logic_unit_seq_if.sv | 35 +++
 rtl/logic_unit_seq.sv | 138 +++++++++++++
 tb/tb_logic_unit_seq.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_unit_seq_if.sv
// Request/response bundle between the ALU controller and logic_unit_seq.
//   master : controller side (drives start/op/a/b, observes busy/done/results)
//   slave  : logic unit side
// Signals:
//   start  request, sampled by the unit only while idle
//   op     operation select (3 bits)
//   a, b   operands, WIDTH bits
//   busy   high while slices are being processed
//   done   one-cycle pulse; result/zero/ones valid
//   result WIDTH-bit result, zero flag, ones = popcount (CNT_W bits)
interface logic_unit_seq_if #(
   parameter int unsigned WIDTH = 16
);
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic [CNT_W-1:0] ones;

   modport master (
      output start, op, a, b,
      input  busy, done, result, zero, ones
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result, zero, ones
   );
endinterface

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: applies one of eight bitwise operations
// to two WIDTH-bit operands, SLICE bits per clock, and reports a zero flag
// and the population count of the result.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  logic_unit_seq_if.slave (start/op/a/b in; busy/done/result/zero/ones out)
// Parameters:
//   WIDTH operand width, must be a multiple of SLICE (and match bus WIDTH)
//   SLICE bits processed per clock; NS = WIDTH/SLICE cycles per operation
// op: 000 AND, 001 OR, 010 XOR, 011 XNOR, 100 NAND, 101 NOR, 110 NOT A, 111 PASS A
module logic_unit_seq #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SLICE = 4
) (
   input logic              clk,
   input logic              rst,
   logic_unit_seq_if.slave  bus
);

   localparam int unsigned NS    = WIDTH / SLICE;
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam int unsigned IDX_W = (NS > 1) ? $clog2(NS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] result_q;
   logic [CNT_W-1:0] ones_q;
   logic             zero_q;
   logic             busy_q;
   logic             done_q;

   logic [SLICE-1:0] a_s;
   logic [SLICE-1:0] b_s;
   logic [SLICE-1:0] slice_res_c;
   logic [CNT_W-1:0] slice_cnt_c;
   logic [CNT_W-1:0] ones_next_c;
   logic [WIDTH-1:0] slice_place_c;

   // Current slice: latched operands are shifted right each BUSY cycle, so
   // the slice being worked on always sits in the low SLICE bits.
   always_comb begin
      a_s         = a_sh[SLICE-1:0];
      b_s         = b_sh[SLICE-1:0];
      slice_res_c = '0;
      case (op_q)
         3'b000:  slice_res_c = a_s & b_s;
         3'b001:  slice_res_c = a_s | b_s;
         3'b010:  slice_res_c = a_s ^ b_s;
         3'b011:  slice_res_c = ~(a_s ^ b_s);
         3'b100:  slice_res_c = ~(a_s & b_s);
         3'b101:  slice_res_c = ~(a_s | b_s);
         3'b110:  slice_res_c = ~a_s;
         default: slice_res_c = a_s;
      endcase

      slice_cnt_c = '0;
      for (int i = 0; i < int'(SLICE); i++) begin
         slice_cnt_c = slice_cnt_c + CNT_W'(slice_res_c[i]);
      end
      ones_next_c = ones_q + slice_cnt_c;

      // Result is cleared on accept, so OR-ing the slice into its place is
      // equivalent to writing result[idx*SLICE +: SLICE].
      slice_place_c = WIDTH'(slice_res_c) << (32'(idx) * 32'(SLICE));
   end

   // Control FSM and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         idx      <= '0;
         op_q     <= '0;
         a_sh     <= '0;
         b_sh     <= '0;
         result_q <= '0;
         ones_q   <= '0;
         zero_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  op_q     <= bus.op;
                  a_sh     <= bus.a;
                  b_sh     <= bus.b;
                  result_q <= '0;
                  ones_q   <= '0;
                  idx      <= '0;
                  busy_q   <= 1'b1;
                  state    <= BUSY;
               end
            end
            BUSY: begin
               result_q <= result_q | slice_place_c;
               ones_q   <= ones_next_c;
               a_sh     <= a_sh >> SLICE;
               b_sh     <= b_sh >> SLICE;
               if (idx == LAST_IDX) begin
                  idx    <= '0;
                  zero_q <= (ones_next_c == '0);
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  state  <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            DONE: begin
               // start is ignored here; the controller re-asserts in IDLE.
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.zero   = zero_q;
   assign bus.ones   = ones_q;

endmodule

// File: tb/tb_logic_unit_seq.sv
// Testbench for logic_unit_seq: 16/4 instance checked every cycle against a
// word-level model, plus hand-computed vectors; 8/8 and 8/1 instances for
// the parameter sweep.
module tb_logic_unit_seq;

   localparam int NS16 = 4;

   logic clk;
   logic rst;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   logic_unit_seq_if #(.WIDTH(16)) bus16 ();
   logic_unit_seq_if #(.WIDTH(8))  bus8a ();
   logic_unit_seq_if #(.WIDTH(8))  bus8b ();

   logic_unit_seq #(.WIDTH(16), .SLICE(4)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));
   logic_unit_seq #(.WIDTH(8),  .SLICE(8)) u_dut8a (.clk(clk), .rst(rst), .bus(bus8a));
   logic_unit_seq #(.WIDTH(8),  .SLICE(1)) u_dut8b (.clk(clk), .rst(rst), .bus(bus8b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- word-level model of the 16-bit instance ----------------
   function automatic logic [15:0] f16(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
      case (o)
         3'd0:    return x & y;
         3'd1:    return x | y;
         3'd2:    return x ^ y;
         3'd3:    return ~(x ^ y);
         3'd4:    return ~(x & y);
         3'd5:    return ~(x | y);
         3'd6:    return ~x;
         default: return x;
      endcase
   endfunction

   bit          m_act  = 1'b0;
   int          m_t    = 0;     // edges since accept
   logic [15:0] m_fin  = '0;
   logic [15:0] m_res  = '0;
   int          m_ones = 0;
   logic        m_zero = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_act = 1'b0; m_t = 0; m_res = '0; m_ones = 0; m_zero = 1'b0;
      end else if (!m_act) begin
         if (bus16.start === 1'b1) begin
            m_act = 1'b1; m_t = 0;
            m_fin = f16(bus16.op, bus16.a, bus16.b);
            m_res = '0; m_ones = 0;
         end
      end else begin
         m_t++;
         if (m_t == NS16) begin
            m_res  = m_fin;
            m_ones = $countones(m_fin);
            m_zero = (m_fin == 16'h0000);
         end else if (m_t == NS16 + 1) begin
            m_act = 1'b0;
         end
      end
   end

   // Compare process: outputs every cycle; result/ones only when not busy.
   always @(negedge clk) begin
      if (chk_en) begin
         bit e_busy;
         bit e_done;
         e_busy = m_act && (m_t < NS16);
         e_done = m_act && (m_t == NS16);
         check("m_busy", 32'(bus16.busy), 32'(e_busy));
         check("m_done", 32'(bus16.done), 32'(e_done));
         check("m_zero", 32'(bus16.zero), 32'(m_zero));
         if (!e_busy) begin
            check("m_result", 32'(bus16.result), 32'(m_res));
            check("m_ones",   32'(bus16.ones),   32'(m_ones));
         end
      end
   end

   // Issue one op on the 16-bit instance; lat counts negedges from the
   // accepting edge's cycle up to the one showing done (NS+1 expected).
   task automatic go16(input logic [2:0] o, input logic [15:0] av, input logic [15:0] bv, output int lat);
      @(negedge clk);
      bus16.op = o; bus16.a = av; bus16.b = bv; bus16.start = 1'b1;
      @(negedge clk);
      lat = 1;
      bus16.start = 1'b0;
      while (bus16.done !== 1'b1 && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      if (bus16.done !== 1'b1) check("done16_timeout", 32'd0, 32'd1);
   endtask

   task automatic run16(input string nm, input logic [2:0] o, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] er, input int eo, input bit ez);
      int lat;
      go16(o, av, bv, lat);
      check({nm, "_lat"},    32'(lat), 32'(NS16 + 1));
      check({nm, "_result"}, 32'(bus16.result), 32'(er));
      check({nm, "_ones"},   32'(bus16.ones), 32'(eo));
      check({nm, "_zero"},   32'(bus16.zero), 32'(ez));
   endtask

   task automatic run8(input bit sel, input logic [2:0] o, input logic [7:0] av, input logic [7:0] bv,
                       output int lat, output logic [7:0] r, output logic [3:0] n, output logic z);
      logic dn;
      @(negedge clk);
      if (sel) begin
         bus8b.op = o; bus8b.a = av; bus8b.b = bv; bus8b.start = 1'b1;
      end else begin
         bus8a.op = o; bus8a.a = av; bus8a.b = bv; bus8a.start = 1'b1;
      end
      @(negedge clk);
      lat = 1;
      bus8a.start = 1'b0;
      bus8b.start = 1'b0;
      dn = sel ? bus8b.done : bus8a.done;
      while (dn !== 1'b1 && lat < 60) begin
         @(negedge clk);
         lat++;
         dn = sel ? bus8b.done : bus8a.done;
      end
      if (dn !== 1'b1) check("done8_timeout", 32'd0, 32'd1);
      r = sel ? bus8b.result : bus8a.result;
      n = sel ? bus8b.ones   : bus8a.ones;
      z = sel ? bus8b.zero   : bus8a.zero;
   endtask

   initial begin
      int          lat;
      int          nd;
      int          d0, d1;
      logic [15:0] r0, r1;
      logic [7:0]  r8;
      logic [3:0]  n8;
      logic        z8;

      rst = 1'b1;
      bus16.start = 1'b0; bus16.op = '0; bus16.a = '0; bus16.b = '0;
      bus8a.start = 1'b0; bus8a.op = '0; bus8a.a = '0; bus8a.b = '0;
      bus8b.start = 1'b0; bus8b.op = '0; bus8b.a = '0; bus8b.b = '0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      check("rst_busy",   32'(bus16.busy),   32'd0);
      check("rst_done",   32'(bus16.done),   32'd0);
      check("rst_result", 32'(bus16.result), 32'd0);
      check("rst_ones",   32'(bus16.ones),   32'd0);
      rst = 1'b0;

      // Hand-computed vectors.
      run16("xnor",  3'b011, 16'h04E8, 16'h0DEC, 16'hF6FB, 13, 1'b0);
      run16("and",   3'b000, 16'h04E8, 16'h0DEC, 16'h04E8,  5, 1'b0);
      run16("nor",   3'b101, 16'h04E8, 16'h0DEC, 16'hF213,  8, 1'b0);
      run16("xor_z", 3'b010, 16'hA5A5, 16'hA5A5, 16'h0000,  0, 1'b1);
      run16("xnor1", 3'b011, 16'hA5A5, 16'hA5A5, 16'hFFFF, 16, 1'b0);
      run16("xor_z2",3'b010, 16'hA5A5, 16'hA5A5, 16'h0000,  0, 1'b1);

      // Reset during an operation (zero is 1 beforehand so clearing shows).
      @(negedge clk);
      bus16.op = 3'b011; bus16.a = 16'h04E8; bus16.b = 16'h0DEC; bus16.start = 1'b1;
      @(negedge clk);
      bus16.start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy",   32'(bus16.busy),   32'd0);
      check("abort_done",   32'(bus16.done),   32'd0);
      check("abort_result", 32'(bus16.result), 32'd0);
      check("abort_ones",   32'(bus16.ones),   32'd0);
      check("abort_zero",   32'(bus16.zero),   32'd0);
      rst = 1'b0;
      nd = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus16.done === 1'b1) nd++;
      end
      check("abort_no_done", 32'(nd), 32'd0);
      run16("fresh", 3'b011, 16'h04E8, 16'h0DEC, 16'hF6FB, 13, 1'b0);

      // start held high; a changed while busy.
      @(negedge clk);
      bus16.op = 3'b011; bus16.a = 16'h04E8; bus16.b = 16'h0DEC; bus16.start = 1'b1;
      nd = 0; d0 = 0; d1 = 0; r0 = '0; r1 = '0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (c == 1) bus16.a = 16'hFFFF;
         if (bus16.done === 1'b1) begin
            if (nd == 0) begin d0 = c; r0 = bus16.result; end
            if (nd == 1) begin d1 = c; r1 = bus16.result; end
            nd++;
         end
      end
      bus16.start = 1'b0;
      check("hold_dones",  32'(nd), 32'd2);
      check("hold_first",  32'(d0), 32'(NS16 + 1));
      check("hold_period", 32'(d1 - d0), 32'(NS16 + 2));
      check("hold_res0",   32'(r0), 32'h0000_F6FB);
      check("hold_res1",   32'(r1), 32'h0000_0DEC);

      // Every op once with random operands; checked by the model.
      for (int o = 0; o < 8; o++) begin
         go16(3'(o), 16'($urandom), 16'($urandom), lat);
         check("rand_lat", 32'(lat), 32'(NS16 + 1));
      end

      // Parameter sweep: WIDTH=8 with NS=1 and NS=8.
      run8(1'b0, 3'b110, 8'h3C, 8'hFF, lat, r8, n8, z8);
      check("ns1_lat",    32'(lat), 32'd2);
      check("ns1_result", 32'(r8),  32'h0000_00C3);
      check("ns1_ones",   32'(n8),  32'd4);
      check("ns1_zero",   32'(z8),  32'd0);
      run8(1'b1, 3'b110, 8'h3C, 8'hFF, lat, r8, n8, z8);
      check("ns8_lat",    32'(lat), 32'd9);
      check("ns8_result", 32'(r8),  32'h0000_00C3);
      check("ns8_ones",   32'(n8),  32'd4);
      check("ns8_zero",   32'(z8),  32'd0);
      run8(1'b1, 3'b001, 8'hF0, 8'h0F, lat, r8, n8, z8);
      check("ns8_or_result", 32'(r8), 32'h0000_00FF);
      check("ns8_or_ones",   32'(n8), 32'd8);
      run8(1'b1, 3'b111, 8'h00, 8'hFF, lat, r8, n8, z8);
      check("ns8_pass_zero", 32'(z8), 32'd1);
      check("ns8_pass_ones", 32'(n8), 32'd0);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
